mux_4: RTL and testbench

- Parameterised 4:1 data multiplexer used as a generic datapath selector, e.g. for operand or result selection in the MCU pipeline.
- Provides a combinational select path and a registered copy of the selected word.
- The registered copy has a valid flag, for timing-critical consumers.
- Single clock domain.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_2.sv | 14 +
 rtl/mux_4.sv | 71 +++++++
 tb/tb_mux_4.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: select width and symbolic select codes.
package mux_pkg;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_IN0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_IN1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_IN2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_IN3 = 2'd3;

endpackage

// File: rtl/mux_2.sv
// 2:1 data selector, leaf cell of the mux_4 select tree.
module mux_2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // sel = 0 passes a, sel = 1 passes b
    assign y = sel ? b : a;

endmodule

// File: rtl/mux_4.sv
// 4:1 data selector with a combinational output and a registered, valid-qualified copy.
// Optional macro MUX4_SEL_X_CHECK_EN: in simulation, forces out to X and reports an
// error when sel is unknown during a valid cycle. Synthesised logic is identical.
module mux_4
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_vld,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic                  out_q_vld
);

    logic [3:0][DATA_WIDTH-1:0] ins;
    logic [1:0][DATA_WIDTH-1:0] pair;
    logic [DATA_WIDTH-1:0]      tree_out;

    assign ins = {in3, in2, in1, in0};

    // First level: sel[0] picks within {in0,in1} and {in2,in3}
    for (genvar g = 0; g < 2; g++) begin : g_pair
        mux_2 #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
            .sel (sel[0]),
            .a   (ins[2*g]),
            .b   (ins[2*g+1]),
            .y   (pair[g])
        );
    end

    // Second level: sel[1] picks between the pair results
    mux_2 #(.DATA_WIDTH(DATA_WIDTH)) u_top (
        .sel (sel[1]),
        .a   (pair[0]),
        .b   (pair[1]),
        .y   (tree_out)
    );

`ifdef MUX4_SEL_X_CHECK_EN
    // Make an unknown select visible downstream instead of letting the tree resolve it
    assign out = $isunknown(sel) ? {DATA_WIDTH{1'bx}} : tree_out;

    // Flag every valid cycle that presents an unknown select
    always @(posedge clk) begin
        if (rst_n && in_vld && $isunknown(sel))
            $error("mux_4: sel is X/Z while in_vld is high");
    end
`else
    assign out = tree_out;
`endif

    // Registered copy: reset wins, otherwise capture on in_vld and hold the word when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_q_vld <= 1'b0;
        end else begin
            out_q_vld <= in_vld;
            if (in_vld)
                out_q <= out;
        end
    end

endmodule

// File: tb/tb_mux_4.sv
// Directed bench for mux_4 at DATA_WIDTH = 64: select table plus registered-path sequences.
module tb_mux_4;
    import mux_pkg::*;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in0, in1, in2, in3;
    logic [1:0]    sel;
    logic          in_vld;
    logic [DW-1:0] out, out_q;
    logic          out_q_vld;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0]    s;
        logic [DW-1:0] d0, d1, d2, d3;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [8];

    mux_4 #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .sel       (sel),
        .in_vld    (in_vld),
        .out       (out),
        .out_q     (out_q),
        .out_q_vld (out_q_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{SEL_IN0, 64'h0, 64'h1, 64'h2, 64'h3, 64'h0};
        tbl[1] = '{SEL_IN1, 64'h0, 64'h1, 64'h2, 64'h3, 64'h1};
        tbl[2] = '{SEL_IN2, 64'h0, 64'h1, 64'h2, 64'h3, 64'h2};
        tbl[3] = '{SEL_IN3, 64'h0, 64'h1, 64'h2, 64'h3, 64'h3};
        tbl[4] = '{SEL_IN3, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        tbl[5] = '{SEL_IN0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hA5A5_A5A5_A5A5_A5A5};
        tbl[6] = '{SEL_IN2, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[7] = '{SEL_IN1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h5A5A_5A5A_5A5A_5A5A};

        // Reset held two cycles with a valid request pending
        rst_n  = 1'b0;
        in_vld = 1'b1;
        sel    = SEL_IN3;
        in0 = 64'h0; in1 = 64'h1; in2 = 64'h2; in3 = 64'h3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_q", out_q, '0);
            chk("rst_out_q_vld", {63'b0, out_q_vld}, 64'h0);
            chk("rst_out", out, 64'h3);
        end

        // Combinational select table, one step per time unit
        rst_n  = 1'b1;
        in_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = tbl[i].s;
            in0 = tbl[i].d0; in1 = tbl[i].d1; in2 = tbl[i].d2; in3 = tbl[i].d3;
            #1;
            chk($sformatf("tbl_out[%0d]", i), out, tbl[i].exp);
        end
        chk("idle_out_q", out_q, '0);
        chk("idle_out_q_vld", {63'b0, out_q_vld}, 64'h0);

        // Single valid capture, then hold with valid dropping
        @(negedge clk);
        in1    = 64'h1111_2222_3333_4444;
        sel    = SEL_IN1;
        in_vld = 1'b1;
        tick();
        chk("cap_out_q", out_q, 64'h1111_2222_3333_4444);
        chk("cap_out_q_vld", {63'b0, out_q_vld}, 64'h1);
        in_vld = 1'b0;
        in1    = 64'hFFFF_0000_FFFF_0000;
        tick();
        chk("hold_out_q", out_q, 64'h1111_2222_3333_4444);
        chk("hold_out_q_vld", {63'b0, out_q_vld}, 64'h0);
        chk("hold_out", out, 64'hFFFF_0000_FFFF_0000);

        // Selected input changes: out follows immediately, out_q only at the next valid edge
        sel = SEL_IN2;
        in2 = 64'h2;
        #1;
        chk("chg_out_before", out, 64'h2);
        in2 = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("chg_out_after", out, 64'hDEAD_BEEF_0000_0001);
        chk("chg_out_q_held", out_q, 64'h1111_2222_3333_4444);
        in_vld = 1'b1;
        tick();
        chk("chg_out_q", out_q, 64'hDEAD_BEEF_0000_0001);
        chk("chg_out_q_vld", {63'b0, out_q_vld}, 64'h1);

        // Reset right after a capture overrides a pending valid
        rst_n  = 1'b0;
        sel    = SEL_IN3;
        in3    = 64'h0123_4567_89AB_CDEF;
        in_vld = 1'b1;
        tick();
        chk("rstpri_out_q", out_q, '0);
        chk("rstpri_out_q_vld", {63'b0, out_q_vld}, 64'h0);
        chk("rstpri_out", out, 64'h0123_4567_89AB_CDEF);

        // Capture resumes once reset is released
        rst_n = 1'b1;
        tick();
        chk("resume_out_q", out_q, 64'h0123_4567_89AB_CDEF);
        chk("resume_out_q_vld", {63'b0, out_q_vld}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
